// File: rtl/kyber_pkg.sv
// kyber_pkg: shared key-bank constants and types for the key-generation output path
package kyber_pkg;
  localparam int K_ROWS = 2;
  localparam int K_COLS = 4;
  localparam int KEY_W  = 32;
  typedef logic [KEY_W-1:0] key_word_t;
  typedef key_word_t [K_ROWS-1:0][K_COLS-1:0] key_bank_t;
  typedef enum logic {IDLE, STREAM} kstx_state_t;
endpackage

// File: rtl/key_stream_tx.sv
// key_stream_tx: captures a key bank on load and streams it row-major over valid/ready
module key_stream_tx
  import kyber_pkg::*;
#(
  parameter int ROWS   = K_ROWS,
  parameter int COLS   = K_COLS,
  parameter int WORD_W = KEY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [WORD_W-1:0]        keys_in [ROWS-1:0][COLS-1:0],
  input  logic                     flush,
  input  logic                     clear_err,
  output logic [WORD_W-1:0]        tdata,
  output logic                     tvalid,
  input  logic                     tready,
  output logic [$clog2(ROWS)-1:0]  trow,
  output logic [$clog2(COLS)-1:0]  tcol,
  output logic                     tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(COLS);
  kstx_state_t       r_state;
  logic [IW-1:0]     r_idx;
  logic [WORD_W-1:0] r_bank [ROWS-1:0][COLS-1:0];
  logic              r_done;
  logic              r_ovr;
  logic              w_hs;
  logic              w_last;
  logic              w_fin;
  logic              w_cap;
  logic              w_ovr_set;
  // Handshake qualification; outputs come only from registers so tready never reaches tvalid
  always_comb begin
    tvalid    = r_state == STREAM;
    w_hs      = tvalid & tready;
    w_last    = r_idx == IW'(N - 1);
    w_fin     = w_hs & w_last & !flush;
    w_cap     = load & !flush & (r_state == IDLE | w_fin);
    w_ovr_set = tvalid & load & !flush & !w_fin;
    tcol      = r_idx[CW-1:0];
    trow      = r_idx[IW-1:CW];
    tdata     = r_bank[trow][tcol];
    tlast     = tvalid & w_last;
    busy      = tvalid;
    done      = r_done;
    overrun   = r_ovr;
  end
  // FSM, bank capture and index counter; the counter only reloads on capture and never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_bank  <= '{default: '0};
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= w_fin;
      r_ovr  <= w_ovr_set | (r_ovr & !clear_err);
      if (w_cap) begin
        r_bank  <= keys_in;
        r_idx   <= '0;
        r_state <= STREAM;
      end else if ((tvalid & flush) | w_fin) begin
        r_state <= IDLE;
      end else if (w_hs) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/key_stream_tx.md
Name: key_stream_tx

Overview:
- Reader/transmitter end of the key-generation output.
- Captures one 2x4 bank of 32-bit key words in a single cycle, on a load strobe.
- Streams the bank out word by word over a valid/ready interface to the downstream encryption/NTT datapath.
- Tags each beat with its row/column index and marks the final word.

Parameters:
- ROWS, 2, number of key rows (polynomials).
- COLS, 4, words per row.
- WORD_W, 32, key word width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- load  in  1  capture strobe; samples keys_in when accepted.
- keys_in  in  ROWS x COLS x WORD_W  unpacked key bank [ROWS-1:0][COLS-1:0].
- flush  in  1  synchronous abort of the current stream.
- clear_err  in  1  clears the overrun flag.
- tdata  out  WORD_W  current key word.
- tvalid  out  1  tdata/trow/tcol/tlast valid.
- tready  in  1  downstream accepts the beat.
- trow  out  clog2(ROWS)  row index of the current word.
- tcol  out  clog2(COLS)  column index of the current word.
- tlast  out  1  high on the word [ROWS-1][COLS-1].
- busy  out  1  high while in STREAM.
- done  out  1  one-cycle pulse after the final handshake.
- overrun  out  1  sticky; a load arrived while busy and was dropped.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE; bank registers and the index counter are 0.
  - tvalid, tlast, busy, done and overrun are 0; tdata, trow and tcol are 0.
- State IDLE:
  - load=1 captures all ROWS*COLS words in the same edge, sets index to 0 and moves to STREAM.
  - Latency: load at edge N gives tvalid=1 with word [0][0] after edge N.
- State STREAM:
  - tvalid=1 and tdata=bank[row][col]; trow/tcol track the counter.
  - Order is row-major: [0][0],[0][1],...,[0][COLS-1],[1][0],...
  - A handshake is tvalid&tready at a clock edge; it advances the index by one.
  - With tready low, tdata, trow, tcol and tlast hold stable (AXI-style; no combinational path from tready to tvalid).
  - tlast is 1 only on index ROWS*COLS-1.
  - Handshake on the last word, load=0: go to IDLE; tvalid drops; done=1 for exactly one cycle.
  - Handshake on the last word, load=1 in the same cycle: capture the new bank, index to 0, stay in STREAM. tvalid stays high with new [0][0] next cycle, done pulses, no overrun.
  - load in STREAM at any other time: bank is untouched; overrun is set to 1 next cycle.
- flush:
  - Highest priority in STREAM: go to IDLE next cycle; tvalid, tlast and busy drop; no done pulse; bank contents are don't-care.
  - In IDLE, flush=1 with load=1: flush wins and the load is ignored; no overrun.
- overrun clearing:
  - clear_err=1 clears overrun next cycle.
  - A set event in the same cycle wins, so overrun stays 1.
- Counter:
  - Width is clog2(ROWS*COLS).
  - It never wraps past the last word; it is reloaded to 0 only on capture.
- Reset asserted mid-stream: immediate return to the reset values above; a partial stream is not resumed.

Decomposition:
- Shared package kyber_pkg:
  - Constants K_ROWS=2, K_COLS=4, KEY_W=32.
  - typedef key_word_t (logic [KEY_W-1:0]).
  - typedef key_bank_t (key_word_t [K_ROWS-1:0][K_COLS-1:0]).
  - enum kstx_state_t {IDLE, STREAM}.
- Single module; no sub-module is needed. The index counter and FSM are small enough to stay inline.

Test Plan:
- Basic stream:
  - Stimulus: reset; load with keys[i][j]=32'h1000_0000+i*16+j; tready held 1.
  - Response: 8 beats on consecutive cycles, tdata 10000000,01,02,03,10,11,12,13; trow/tcol match; tlast only on beat 8; done pulses the cycle after; busy=0 afterwards.
- Backpressure:
  - Stimulus: same bank; tready toggles 1,0,0,1,... (pattern 1001 repeated).
  - Response: each word stays stable while tready=0; no word skipped or duplicated; total 8 handshakes.
- Overrun:
  - Stimulus: load bank A; pulse load with bank B during beat 3.
  - Response: all 8 beats are bank A; overrun=1 sticky; clear_err pulse gives overrun=0 next cycle.
- Back-to-back:
  - Stimulus: load asserted on the last-word handshake with bank C=32'hC0DE_00xx.
  - Response: tvalid never drops; next beat is C[0][0]; done pulses once; overrun stays 0.
- Flush:
  - Stimulus: flush during beat 5 with tready=0.
  - Response: tvalid=0 next cycle; no done pulse; a subsequent load streams a fresh bank from [0][0].
- Async reset:
  - Stimulus: rst_n low mid-stream, asynchronous to clk.
  - Response: tvalid, busy and overrun are 0 immediately; after release, a load restarts streaming normally.
